// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Round-robin arbiter sharing one data-memory port between LSUs,
//            one transaction in flight. Optional DATA_MEM_ARB_WRITE_FIRST_EN
//            gives every pending write priority over every pending read.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int NUM_CONSUMERS      = 4,
    parameter int DATA_MEM_ADDR_BITS = 8,
    parameter int DATA_MEM_DATA_BITS = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_CONSUMERS-1:0]                     consumer_read_valid,
    input  logic [NUM_CONSUMERS*DATA_MEM_ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                     consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_MEM_DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                     consumer_write_valid,
    input  logic [NUM_CONSUMERS*DATA_MEM_ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_MEM_DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                     consumer_write_ready,
    output logic                                         mem_read_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                mem_read_address,
    input  logic                                         mem_read_ready,
    input  logic [DATA_MEM_DATA_BITS-1:0]                mem_read_data,
    output logic                                         mem_write_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                mem_write_address,
    output logic [DATA_MEM_DATA_BITS-1:0]                mem_write_data,
    input  logic                                         mem_write_ready,
    output logic                                         busy
);

    localparam int c_N     = NUM_CONSUMERS;
    localparam int c_A     = DATA_MEM_ADDR_BITS;
    localparam int c_D     = DATA_MEM_DATA_BITS;
    localparam int c_PTR_W = $clog2(c_N);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_READ_WAIT  = 2'd1;
    localparam logic [1:0] c_WRITE_WAIT = 2'd2;
    localparam logic [1:0] c_RELAY      = 2'd3;

    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(c_N - 1);

    logic [1:0]         r_state,         w_state_nxt;
    logic [c_PTR_W-1:0] r_grant,         w_grant_nxt;
    logic [c_PTR_W-1:0] r_rr_ptr,        w_rr_ptr_nxt;
    logic               r_is_read,       w_is_read_nxt;
    logic               r_mem_rd_valid,  w_mem_rd_valid_nxt;
    logic [c_A-1:0]     r_mem_rd_addr,   w_mem_rd_addr_nxt;
    logic               r_mem_wr_valid,  w_mem_wr_valid_nxt;
    logic [c_A-1:0]     r_mem_wr_addr,   w_mem_wr_addr_nxt;
    logic [c_D-1:0]     r_mem_wr_data,   w_mem_wr_data_nxt;
    logic [c_N-1:0]     r_cons_rd_ready, w_cons_rd_ready_nxt;
    logic [c_N*c_D-1:0] r_cons_rd_data,  w_cons_rd_data_nxt;
    logic [c_N-1:0]     r_cons_wr_ready, w_cons_wr_ready_nxt;
    logic               r_busy,          w_busy_nxt;

    logic               w_found;
    logic               w_sel_read;
    logic [c_PTR_W-1:0] w_sel;
    logic               w_req_low;

    // Requester index rr_ptr+k, wrapped modulo N (N need not be a power of 2).
    function automatic logic [c_PTR_W-1:0] f_wrap(input logic [c_PTR_W-1:0] base, input int k);
        int v_sum;
        v_sum = int'(base) + k;
        if (v_sum >= c_N) v_sum = v_sum - c_N;
        return c_PTR_W'(v_sum);
    endfunction

    always_comb begin
        w_found    = 1'b0;
        w_sel_read = 1'b0;
        w_sel      = '0;
`ifdef DATA_MEM_ARB_WRITE_FIRST_EN
        for (int k = 0; k < c_N; k++) begin
            if (!w_found && consumer_write_valid[f_wrap(r_rr_ptr, k)]) begin
                w_found    = 1'b1;
                w_sel_read = 1'b0;
                w_sel      = f_wrap(r_rr_ptr, k);
            end
        end
        for (int k = 0; k < c_N; k++) begin
            if (!w_found && consumer_read_valid[f_wrap(r_rr_ptr, k)]) begin
                w_found    = 1'b1;
                w_sel_read = 1'b1;
                w_sel      = f_wrap(r_rr_ptr, k);
            end
        end
`else
        for (int k = 0; k < c_N; k++) begin
            if (!w_found && (consumer_read_valid[f_wrap(r_rr_ptr, k)] ||
                             consumer_write_valid[f_wrap(r_rr_ptr, k)])) begin
                w_found    = 1'b1;
                w_sel_read = consumer_read_valid[f_wrap(r_rr_ptr, k)];
                w_sel      = f_wrap(r_rr_ptr, k);
            end
        end
`endif
    end

    assign w_req_low = r_is_read ? ~consumer_read_valid[r_grant] : ~consumer_write_valid[r_grant];

    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        w_rr_ptr_nxt        = r_rr_ptr;
        w_is_read_nxt       = r_is_read;
        w_mem_rd_valid_nxt  = r_mem_rd_valid;
        w_mem_rd_addr_nxt   = r_mem_rd_addr;
        w_mem_wr_valid_nxt  = r_mem_wr_valid;
        w_mem_wr_addr_nxt   = r_mem_wr_addr;
        w_mem_wr_data_nxt   = r_mem_wr_data;
        w_cons_rd_ready_nxt = r_cons_rd_ready;
        w_cons_rd_data_nxt  = r_cons_rd_data;
        w_cons_wr_ready_nxt = r_cons_wr_ready;

        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_grant_nxt   = w_sel;
                    w_is_read_nxt = w_sel_read;
                    if (w_sel_read) begin
                        w_mem_rd_valid_nxt = 1'b1;
                        w_mem_rd_addr_nxt  = consumer_read_address[int'(w_sel)*c_A +: c_A];
                        w_state_nxt        = c_READ_WAIT;
                    end else begin
                        w_mem_wr_valid_nxt = 1'b1;
                        w_mem_wr_addr_nxt  = consumer_write_address[int'(w_sel)*c_A +: c_A];
                        w_mem_wr_data_nxt  = consumer_write_data[int'(w_sel)*c_D +: c_D];
                        w_state_nxt        = c_WRITE_WAIT;
                    end
                end
            end
            c_READ_WAIT: begin
                if (r_mem_rd_valid && mem_read_ready) begin
                    w_mem_rd_valid_nxt                      = 1'b0;
                    w_mem_rd_addr_nxt                       = '0;
                    w_cons_rd_ready_nxt[r_grant]            = 1'b1;
                    w_cons_rd_data_nxt[int'(r_grant)*c_D +: c_D] = mem_read_data;
                    w_state_nxt                             = c_RELAY;
                end
            end
            c_WRITE_WAIT: begin
                if (r_mem_wr_valid && mem_write_ready) begin
                    w_mem_wr_valid_nxt           = 1'b0;
                    w_mem_wr_addr_nxt            = '0;
                    w_mem_wr_data_nxt            = '0;
                    w_cons_wr_ready_nxt[r_grant] = 1'b1;
                    w_state_nxt                  = c_RELAY;
                end
            end
            c_RELAY: begin
                // Held until the requester retires its valid; a dropped request exits at once.
                if (w_req_low) begin
                    w_cons_rd_ready_nxt = '0;
                    w_cons_rd_data_nxt  = '0;
                    w_cons_wr_ready_nxt = '0;
                    w_rr_ptr_nxt        = (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
                    w_state_nxt         = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_grant         <= '0;
            r_rr_ptr        <= '0;
            r_is_read       <= 1'b0;
            r_mem_rd_valid  <= 1'b0;
            r_mem_rd_addr   <= '0;
            r_mem_wr_valid  <= 1'b0;
            r_mem_wr_addr   <= '0;
            r_mem_wr_data   <= '0;
            r_cons_rd_ready <= '0;
            r_cons_rd_data  <= '0;
            r_cons_wr_ready <= '0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_grant         <= w_grant_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_is_read       <= w_is_read_nxt;
            r_mem_rd_valid  <= w_mem_rd_valid_nxt;
            r_mem_rd_addr   <= w_mem_rd_addr_nxt;
            r_mem_wr_valid  <= w_mem_wr_valid_nxt;
            r_mem_wr_addr   <= w_mem_wr_addr_nxt;
            r_mem_wr_data   <= w_mem_wr_data_nxt;
            r_cons_rd_ready <= w_cons_rd_ready_nxt;
            r_cons_rd_data  <= w_cons_rd_data_nxt;
            r_cons_wr_ready <= w_cons_wr_ready_nxt;
            r_busy          <= w_busy_nxt;
        end
    end

    assign consumer_read_ready  = r_cons_rd_ready;
    assign consumer_read_data   = r_cons_rd_data;
    assign consumer_write_ready = r_cons_wr_ready;
    assign mem_read_valid       = r_mem_rd_valid;
    assign mem_read_address     = r_mem_rd_addr;
    assign mem_write_valid      = r_mem_wr_valid;
    assign mem_write_address    = r_mem_wr_addr;
    assign mem_write_data       = r_mem_wr_data;
    assign busy                 = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Scoreboard bench for data_mem_arbiter with a latency-programmable
//            memory responder; honours DATA_MEM_ARB_WRITE_FIRST_EN ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int N = 4;
    localparam int A = 8;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   consumer_read_valid = '0;
    logic [N*A-1:0] consumer_read_address = '0;
    logic [N-1:0]   consumer_read_ready;
    logic [N*D-1:0] consumer_read_data;
    logic [N-1:0]   consumer_write_valid = '0;
    logic [N*A-1:0] consumer_write_address = '0;
    logic [N*D-1:0] consumer_write_data = '0;
    logic [N-1:0]   consumer_write_ready;
    logic           mem_read_valid;
    logic [A-1:0]   mem_read_address;
    logic           mem_read_ready = 1'b0;
    logic [D-1:0]   mem_read_data = '0;
    logic           mem_write_valid;
    logic [A-1:0]   mem_write_address;
    logic [D-1:0]   mem_write_data;
    logic           mem_write_ready = 1'b0;
    logic           busy;

    data_mem_arbiter #(
        .NUM_CONSUMERS(N), .DATA_MEM_ADDR_BITS(A), .DATA_MEM_DATA_BITS(D)
    ) u_dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready),
        .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data),
        .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rd;
        int         idx;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       sb[$];
    logic [7:0] mem [256];
    int         lat = 1;
    int         n_total = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input bit rd, input int i, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.rd = rd; t.idx = i; t.addr = a; t.data = d;
        sb.push_back(t);
    endtask

    task automatic rd_req(input int i, input logic [7:0] a);
        consumer_read_valid[i]         = 1'b1;
        consumer_read_address[i*A +: A] = a;
    endtask

    task automatic wr_req(input int i, input logic [7:0] a, input logic [7:0] d);
        consumer_write_valid[i]          = 1'b1;
        consumer_write_address[i*A +: A] = a;
        consumer_write_data[i*D +: D]    = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    // Retire n responses in whatever order the DUT grants them.
    task automatic serve(input int n);
        for (int k = 0; k < n; k++) begin
            bit got;
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(negedge clk);
                for (int j = 0; j < N; j++) begin
                    if (!got && consumer_read_ready[j]) begin
                        consumer_read_valid[j] = 1'b0; got = 1'b1;
                    end else if (!got && consumer_write_ready[j]) begin
                        consumer_write_valid[j] = 1'b0; got = 1'b1;
                    end
                end
            end
            if (!got) begin
                chk("serve_timeout", 0, 1);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_rd_ready(input int i);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (consumer_read_ready[i]) got = 1'b1;
        end
        if (!got) chk("ready_timeout", 0, 1);
    endtask

    // Memory responder: ready on the lat-th cycle of a valid; checks the request against the scoreboard head.
    initial begin
        int rd_cnt, wr_cnt;
        rd_cnt = 0; wr_cnt = 0;
        forever begin
            @(negedge clk);
            mem_read_ready  = 1'b0;
            mem_write_ready = 1'b0;
            if (reset) begin
                rd_cnt = 0; wr_cnt = 0;
            end else begin
                if (mem_read_valid) begin
                    rd_cnt++;
                    if (rd_cnt >= lat) begin
                        if (sb.size() == 0) chk("mem_rd_unexpected", 1, 0);
                        else begin
                            chk("mem_rd_chan", sb[0].rd, 1);
                            chk("mem_rd_addr", mem_read_address, sb[0].addr);
                        end
                        mem_read_ready = 1'b1;
                        mem_read_data  = mem[mem_read_address];
                        rd_cnt = 0;
                    end
                end else rd_cnt = 0;
                if (mem_write_valid) begin
                    wr_cnt++;
                    if (wr_cnt >= lat) begin
                        if (sb.size() == 0) chk("mem_wr_unexpected", 1, 0);
                        else begin
                            chk("mem_wr_chan", sb[0].rd, 0);
                            chk("mem_wr_addr", mem_write_address, sb[0].addr);
                            chk("mem_wr_data", mem_write_data, sb[0].data);
                        end
                        mem_write_ready = 1'b1;
                        mem[mem_write_address] = mem_write_data;
                        wr_cnt = 0;
                    end
                end else wr_cnt = 0;
            end
        end
    end

    // Response monitor: each new ready pulse retires the scoreboard head.
    initial begin
        logic [2*N-1:0] prev, rdy, rise;
        txn_t t;
        prev = '0;
        forever begin
            @(negedge clk);
            rdy  = {consumer_write_ready, consumer_read_ready};
            rise = rdy & ~prev;
            prev = rdy;
            if (!reset && rise != 0) begin
                chk("ready_onehot", $countones(rdy), 1);
                if (sb.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    t = sb.pop_front();
                    if (t.rd) begin
                        chk("rd_ready_bit", consumer_read_ready, 64'(1) << t.idx);
                        chk("rd_data", consumer_read_data[t.idx*D +: D], t.data);
                    end else begin
                        chk("wr_ready_bit", consumer_write_ready, 64'(1) << t.idx);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        mem[8'h12] = 8'hA5;
        mem[8'h33] = 8'h5C;
        for (int i = 0; i < N; i++) mem[8'h20 + i] = 8'(8'h90 + i);

        // Reset and idle
        do_reset();
        repeat (10) begin
            @(negedge clk);
            chk("idle_memv", {mem_read_valid, mem_write_valid}, 0);
        end
        chk("idle_ctrl", {consumer_read_ready, consumer_write_ready, mem_read_address,
                          mem_write_address, mem_write_data, busy}, 0);
        chk("idle_rd_data", consumer_read_data, 0);

        // Minimum latency
        lat = 1;
        rd_req(0, 8'h33);
        push(1, 0, 8'h33, 8'h5C);
        @(negedge clk);
        chk("lat_memv", mem_read_valid, 1);
        @(negedge clk);
        chk("lat_rdy", consumer_read_ready[0], 1);
        consumer_read_valid[0] = 1'b0;
        @(negedge clk);

        // Requester 1 read, ready on third valid cycle, hold until valid drops
        lat = 3;
        rd_req(1, 8'h12);
        push(1, 1, 8'h12, 8'hA5);
        wait_rd_ready(1);
        repeat (2) begin
            @(negedge clk);
            chk("hold_rdy", consumer_read_ready[1], 1);
            chk("hold_data", consumer_read_data[1*D +: D], 8'hA5);
        end
        consumer_read_valid[1] = 1'b0;
        @(negedge clk);
        chk("rdy_clear", consumer_read_ready, 0);
        chk("busy_clear", busy, 0);

        // Four simultaneous reads from rr_ptr 0, then wrap check
        do_reset();
        lat = 2;
        for (int i = 0; i < N; i++) begin
            rd_req(i, 8'(8'h20 + i));
            push(1, i, 8'(8'h20 + i), 8'(8'h90 + i));
        end
        serve(4);
        rd_req(3, 8'h23);
        rd_req(0, 8'h20);
        push(1, 0, 8'h20, 8'h90);
        push(1, 3, 8'h23, 8'h93);
        serve(2);

        // rr_ptr to 1, then write from 2 vs read from 0
        rd_req(0, 8'h20);
        push(1, 0, 8'h20, 8'h90);
        serve(1);
        wr_req(2, 8'h40, 8'h7E);
        rd_req(0, 8'h21);
        push(0, 2, 8'h40, 8'h7E);
        push(1, 0, 8'h21, 8'h91);
        serve(2);
        chk("mem_40", mem[8'h40], 8'h7E);

        // rr_ptr now 1: read at the pointer vs write further on
        rd_req(1, 8'h22);
        wr_req(3, 8'h50, 8'h3C);
`ifdef DATA_MEM_ARB_WRITE_FIRST_EN
        push(0, 3, 8'h50, 8'h3C);
        push(1, 1, 8'h22, 8'h92);
`else
        push(1, 1, 8'h22, 8'h92);
        push(0, 3, 8'h50, 8'h3C);
`endif
        serve(2);

        // Same requester with read and write pending
        rd_req(2, 8'h23);
        wr_req(2, 8'h51, 8'h44);
`ifdef DATA_MEM_ARB_WRITE_FIRST_EN
        push(0, 2, 8'h51, 8'h44);
        push(1, 2, 8'h23, 8'h93);
`else
        push(1, 2, 8'h23, 8'h93);
        push(0, 2, 8'h51, 8'h44);
`endif
        serve(2);
        chk("mem_51", mem[8'h51], 8'h44);

        // Reset during READ_WAIT with rr_ptr at 2
        do_reset();
        lat = 1;
        rd_req(1, 8'h22);
        push(1, 1, 8'h22, 8'h92);
        serve(1);
        lat = 20;
        rd_req(1, 8'h21);
        repeat (3) @(negedge clk);
        chk("rw_memv", mem_read_valid, 1);
        chk("rw_busy", busy, 1);
        reset = 1'b1;
        consumer_read_valid = '0;
        @(negedge clk);
        chk("abort_memv", mem_read_valid, 0);
        chk("abort_busy", busy, 0);
        reset = 1'b0;
        sb.delete();
        lat = 1;
        rd_req(1, 8'h21);
        rd_req(3, 8'h23);
        push(1, 1, 8'h21, 8'h91);
        push(1, 3, 8'h23, 8'h93);
        serve(2);

        // Requester 3 drops its read during READ_WAIT
        lat = 4;
        rd_req(3, 8'h23);
        push(1, 3, 8'h23, 8'h93);
        repeat (2) @(negedge clk);
        consumer_read_valid[3] = 1'b0;
        wait_rd_ready(3);
        @(negedge clk);
        chk("drop_rdy", consumer_read_ready, 0);
        chk("drop_busy", busy, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
